// File: rtl/if_fetch_stage_pkg.sv
// Shared state encoding and architectural constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HALT = 2'd3
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC    = 32'hbfc0_0000;
  localparam logic [31:0] IF_EXC_VECTOR  = 32'hbfc0_0380;
  localparam logic [31:0] IF_INSTR_BYTES = 32'd4;
  localparam logic [4:0]  IF_EXC_NONE    = 5'h00;
  localparam logic [4:0]  IF_EXC_ADEL    = 5'h04;

  function automatic logic pc_is_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives the SRAM-like instruction
// port and fills a one-entry {pc, instr, excode} buffer for decode.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [4:0]  EXC_ADEL = IF_EXC_ADEL
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        id_ready,
  output logic        instrD_valid,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [4:0]  excodeD
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        discard_q, discard_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [4:0]  exc_q, exc_d;

  logic        redir_s;
  logic [31:0] target_s;
  logic        buf_free_s;

  assign redir_s    = flush || redirect_valid;
  assign target_s   = flush ? flush_pc : redirect_pc;
  assign buf_free_s = !valid_q || id_ready;

  // Next-state: a redirect kills the buffered entry and retargets pc_next, but an
  // in-flight handshake is completed and its data dropped via discard.
  always_comb begin
    state_d   = state_q;
    pc_next_d = redir_s ? target_s : pc_next_q;
    discard_d = discard_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q && !id_ready && !redir_s;
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    exc_d     = exc_q;
    case (state_q)
      IF_IDLE: begin
        if (redir_s) begin
          state_d = IF_IDLE;
        end else if (buf_free_s && pc_is_aligned(pc_next_q)) begin
          addr_d    = pc_next_q;
          pc_next_d = pc_next_q + IF_INSTR_BYTES;
          req_d     = 1'b1;
          state_d   = IF_REQ;
        end else if (buf_free_s) begin
          valid_d = 1'b1;
          instr_d = 32'h0000_0000;
          pcd_d   = pc_next_q;
          exc_d   = EXC_ADEL;
          state_d = IF_HALT;
        end else begin
          state_d = IF_IDLE;
        end
      end
      IF_REQ: begin
        if (inst_addr_ok) begin
          req_d   = 1'b0;
          state_d = IF_WAIT;
        end else begin
          req_d   = 1'b1;
        end
        if (redir_s) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      IF_WAIT: begin
        if (inst_data_ok) begin
          state_d   = IF_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !redir_s) begin
            valid_d = 1'b1;
            instr_d = inst_rdata;
            pcd_d   = addr_q;
            exc_d   = IF_EXC_NONE;
          end else begin
            instr_d = instr_q;
          end
        end else if (redir_s) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      IF_HALT: begin
        if (redir_s) begin
          state_d = IF_IDLE;
        end else begin
          state_d = IF_HALT;
        end
      end
      default: begin
        state_d   = IF_IDLE;
        req_d     = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IF_IDLE;
      pc_next_q <= RESET_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= 32'h0000_0000;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0000_0000;
      pcd_q     <= 32'h0000_0000;
      exc_q     <= 5'h00;
    end else begin
      state_q   <= state_d;
      pc_next_q <= pc_next_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      exc_q     <= exc_d;
    end
  end

  assign inst_req     = req_q;
  assign inst_addr    = addr_q;
  assign instrD_valid = valid_q;
  assign instrD       = instr_q;
  assign pcD          = pcd_q;
  assign excodeD      = exc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage with a bus-level memory model and a
// stream-level reference (expected fetch PC, kill window, expected decode entries).
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_ready;
  logic        instrD_valid;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [4:0]  excodeD;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .flush_pc(flush_pc), .id_ready(id_ready),
    .instrD_valid(instrD_valid), .instrD(instrD), .pcD(pcD), .excodeD(excodeD)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      e_m;
  int          tests = 0;
  int          fails = 0;
  int          consumed = 0;

  // reference-model state
  logic [31:0] sp;
  logic [31:0] m_addr;
  bit          halted, m_out, m_killed;

  // memory-model knobs and state
  int unsigned aok_pct = 100;
  int unsigned dly_min = 0;
  int unsigned dly_max = 0;
  bit          mem_keep = 1'b0;
  bit          hs_seen = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  logic        r_req, r_aok, r_dok, r_rst;
  logic [31:0] r_addr;
  bit          pend = 1'b0;
  int unsigned dly = 0;
  logic [31:0] paddr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7, 0) != 0) t[1:0] = 2'b00;
    if ($urandom_range(15, 0) == 0) t = 32'hffff_fff8;
    return t;
  endfunction

  // SRAM-like instruction memory: random addr_ok, fixed-window data latency, data = addr ^ 1.
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      r_req = inst_req; r_aok = inst_addr_ok; r_dok = inst_data_ok;
      r_rst = resetn;   r_addr = inst_addr;
      #1;
      hs_seen = 1'b0;
      if (!r_rst && !mem_keep) begin
        pend = 1'b0;
        dly  = 0;
      end else begin
        if (r_dok) pend = 1'b0;
        if (r_req && r_aok) begin
          pend = 1'b1; paddr = r_addr; dly = $urandom_range(dly_max, dly_min);
          hs_seen = 1'b1; hs_addr = r_addr;
        end else if (pend && dly > 0) begin
          dly--;
        end
      end
      inst_data_ok = pend && (dly == 0);
      inst_rdata   = inst_data_ok ? (paddr ^ 32'h1) : 32'($urandom);
      inst_addr_ok = ($urandom_range(99, 0) < aok_pct);
    end
  end

  // Monitor/scoreboard: evaluates, mid-cycle, every event the next clock edge will commit.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      sp = IF_RESET_PC; halted = 1'b0; m_out = 1'b0; m_killed = 1'b0;
    end else if (flush || redirect_valid) begin
      exp_q.delete();
      if (inst_req || m_out) m_killed = 1'b1;
      sp = flush ? flush_pc : redirect_pc;
      halted = (sp[1:0] != 2'b00);
      if (halted) exp_q.push_back('{pc: sp, instr: 32'h0, exc: IF_EXC_ADEL});
      if (inst_data_ok && m_out) begin m_out = 1'b0; m_killed = 1'b0; end
      if (inst_req && inst_addr_ok) m_out = 1'b1;
    end else begin
      if (instrD_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_entry: got pc %h instr %h with nothing expected", pcD, instrD);
        end else begin
          e_m = exp_q.pop_front();
          check("entry_pc", pcD, e_m.pc);
          check("entry_instr", instrD, e_m.instr);
          check("entry_excode", {27'd0, excodeD}, {27'd0, e_m.exc});
          consumed++;
        end
      end
      if (inst_data_ok && m_out) begin
        if (!m_killed) begin
          check("buf_empty_on_return", {31'd0, instrD_valid && !id_ready}, 32'd0);
          exp_q.push_back('{pc: m_addr, instr: m_addr ^ 32'h1, exc: IF_EXC_NONE});
        end
        m_out = 1'b0; m_killed = 1'b0;
      end
      if (inst_req && inst_addr_ok) begin
        m_out = 1'b1;
        if (!m_killed) begin
          check("fetch_addr", inst_addr, sp);
          check("no_fetch_while_halted", {31'd0, halted}, 32'd0);
          m_addr = sp;
          sp = sp + 32'd4;
        end
      end
    end
  end

  task automatic wait_hs(input string name, input bit do_chk, input logic [31:0] exp_addr);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #2;
      got = hs_seen;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no fetch handshake within 60 cycles, expected addr %h", name, exp_addr);
    end else if (do_chk) begin
      check(name, hs_addr, exp_addr);
    end
  endtask

  task automatic pulse(input bit rv, input logic [31:0] rpc, input bit fl, input logic [31:0] fpc);
    redirect_valid = rv; redirect_pc = rpc; flush = fl; flush_pc = fpc;
    @(posedge clk); #2;
    redirect_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_inst_req", {31'd0, inst_req}, 32'd0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_instrD_valid", {31'd0, instrD_valid}, 32'd0);
    check("rst_instrD", instrD, 32'h0);
    check("rst_pcD", pcD, 32'h0);
    check("rst_excodeD", {27'd0, excodeD}, 32'd0);
  endtask

  logic [31:0] pc0, a0;
  int          n;
  bit          seen;
  int unsigned r;

  initial begin
    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    resetn = 1'b1;

    // zero-wait latency and sequential fetch
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk); #2;
      if (instrD_valid) n = i;
    end
    check("first_valid_latency", n, 32'd3);
    repeat (10) begin @(posedge clk); #2; end

    // decode stall holds the buffer and blocks requests
    id_ready = 1'b0;
    for (int i = 0; i < 20 && !instrD_valid; i++) begin @(posedge clk); #2; end
    pc0 = pcD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_no_req", {31'd0, inst_req}, 32'd0);
      check("stall_pcD_hold", pcD, pc0);
    end
    id_ready = 1'b1;
    wait_hs("stall_resume_addr", 1'b1, pc0 + 32'd4);

    // redirect while waiting for data
    dly_min = 2; dly_max = 2;
    wait_hs("reach_wait_c", 1'b0, 32'h0);
    pulse(1'b1, 32'h8000_1000, 1'b0, 32'h0);
    wait_hs("redirect_in_wait_addr", 1'b1, 32'h8000_1000);

    // flush+redirect in REQ with addr_ok held off
    dly_min = 0; dly_max = 0; aok_pct = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #2;
      seen = inst_req && !inst_addr_ok;
    end
    a0 = inst_addr;
    pulse(1'b1, 32'h8000_2000, 1'b1, 32'hbfc0_0380);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      check("req_hold_req", {31'd0, inst_req}, 32'd1);
      check("req_hold_addr", inst_addr, a0);
    end
    aok_pct = 100;
    wait_hs("held_addr_handshake", 1'b1, a0);
    wait_hs("flush_wins_addr", 1'b1, 32'hbfc0_0380);

    // misaligned redirect -> AdEL entry, halt, resume on flush
    dly_min = 1; dly_max = 1;
    wait_hs("reach_wait_e", 1'b0, 32'h0);
    pulse(1'b1, 32'h8000_0002, 1'b0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      check("halt_no_req", {31'd0, inst_req}, 32'd0);
      if (instrD_valid && pcD == 32'h8000_0002 && instrD == 32'h0 && excodeD == IF_EXC_ADEL)
        seen = 1'b1;
    end
    check("adel_entry_seen", {31'd0, seen}, 32'd1);
    pulse(1'b0, 32'h0, 1'b1, 32'hbfc0_0380);
    wait_hs("halt_exit_addr", 1'b1, 32'hbfc0_0380);

    // PC wrap
    wait_hs("reach_wait_f", 1'b0, 32'h0);
    pulse(1'b1, 32'hffff_fffc, 1'b0, 32'h0);
    wait_hs("wrap_first", 1'b1, 32'hffff_fffc);
    wait_hs("wrap_second", 1'b1, 32'h0000_0000);

    // reset during WAIT with a stray data_ok afterwards
    mem_keep = 1'b1;
    wait_hs("reach_wait_g", 1'b0, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #2;
    check_reset_outputs();
    resetn = 1'b1;
    mem_keep = 1'b0;
    wait_hs("post_reset_addr", 1'b1, IF_RESET_PC);

    // randomized traffic
    aok_pct = 70; dly_min = 0; dly_max = 3;
    for (int c = 0; c < 2500; c++) begin
      id_ready = ($urandom_range(3, 0) != 0);
      r = $urandom_range(99, 0);
      redirect_pc = rand_target();
      flush_pc = rand_target();
      redirect_valid = (r < 5);
      flush = (r >= 3 && r < 7);
      @(posedge clk); #2;
    end
    redirect_valid = 1'b0; flush = 1'b0; id_ready = 1'b1;
    pulse(1'b1, 32'h8000_4000, 1'b0, 32'h0);
    repeat (40) begin @(posedge clk); #2; end
    tests++;
    if (consumed < 200) begin
      fails++;
      $display("FAIL liveness: consumed %0d entries, required at least 200", consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS core.
- Owns the fetch PC and drives the SRAM-like instruction port.
- Delivers {pc, instr} into a one-entry output buffer that feeds the decode stage and the debug instruction-decoder/ASCII monitor.
- Handles stalls from decode, branch redirects, exception/ERET flushes, and misaligned-PC (AdEL) faults.

Parameters:
- RESET_PC, 32'hbfc0_0000, first fetch address after reset.
- EXC_ADEL, 5'h04, excode reported for a misaligned fetch.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset
- inst_req  out  1  request valid (SRAM-like)
- inst_addr  out  32  request byte address
- inst_addr_ok  in  1  request accepted this cycle
- inst_rdata  in  32  returned instruction
- inst_data_ok  in  1  inst_rdata valid this cycle
- redirect_valid  in  1  branch/jump resolved taken
- redirect_pc  in  32  branch/jump target
- flush  in  1  exception/ERET flush
- flush_pc  in  32  exception vector or EPC
- id_ready  in  1  decode accepts the buffer this cycle
- instrD_valid  out  1  output buffer holds an instruction
- instrD  out  32  instruction word (feeds decoder)
- pcD  out  32  PC of instrD
- excodeD  out  5  0 = none, EXC_ADEL = misaligned fetch

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values:
  - pc_next = RESET_PC; state = IDLE; discard = 0.
  - inst_req = 0; inst_addr = 0.
  - instrD_valid = 0; instrD = 0; pcD = 0; excodeD = 0.
- Buffer free: buf_free = !instrD_valid || id_ready. An accepted buffer clears instrD_valid unless it is reloaded in the same cycle.
- Outstanding requests: at most one. A request is issued only when buf_free, so the buffer is guaranteed empty when its data returns (invariant; assert in the bench).
- States:
  - IDLE: if buf_free && pc_next[1:0] == 0, then inst_addr <= pc_next, pc_next <= pc_next+4, go to REQ. inst_req rises the following cycle.
  - IDLE with pc_next[1:0] != 0 and buf_free: load the buffer with instrD = 0, pcD = pc_next, excodeD = EXC_ADEL, instrD_valid = 1; go to HALT. No bus request is made.
  - REQ: inst_req = 1. inst_addr is held stable until inst_addr_ok. On inst_addr_ok, go to WAIT.
  - WAIT: inst_req = 0. On inst_data_ok:
    - if discard = 0: instrD = inst_rdata, pcD = inst_addr, excodeD = 0, instrD_valid = 1;
    - else drop the data and clear discard;
    - then go to IDLE.
  - HALT: no requests; leaves only on flush or redirect_valid.
- Latency: IDLE -> REQ -> (addr_ok) -> WAIT -> data_ok. With zero-wait memory, instrD_valid rises 3 cycles after leaving IDLE.
- Redirect and flush:
  - flush has priority over redirect_valid; target T = flush ? flush_pc : redirect_pc.
  - Same cycle: pc_next <= T and instrD_valid <= 0 (a buffered wrong-path instruction is killed even if id_ready = 1).
  - State IDLE or HALT: go to IDLE.
  - State REQ: inst_req stays asserted with the old inst_addr until addr_ok (address must not change mid-handshake). discard <= 1; the state path is unchanged.
  - State WAIT: discard <= 1. If inst_data_ok arrives in the same cycle, drop that data and clear discard.
  - redirect/flush while discard = 1 only updates pc_next.
- Simultaneous events:
  - redirect together with data_ok (discard = 0): data dropped, target wins.
  - id_ready together with data_ok: old entry consumed, new entry loaded, instrD_valid stays 1.
- Arithmetic: pc_next + 4 is modulo 2^32 (0xffff_fffc wraps to 0x0000_0000). No exception on wrap.
- Reset mid-transaction: all state clears. A late inst_data_ok after reset, arriving in IDLE, is ignored; the bus model is reset alongside.

Decomposition:
- Shared package (alongside the existing defines header):
  - state encoding IF_IDLE/IF_REQ/IF_WAIT/IF_HALT;
  - RESET_PC and exception-vector constants;
  - EXC_ADEL excode.
- No sub-module needed. The optional one-entry output buffer can be split out as if_out_buf (load/accept/kill) if reuse in later stages is wanted.

Test Plan:
- Reset then zero-wait memory returning inst_rdata = addr^32'h1 -> inst_addr 0xbfc00000, 0xbfc00004, 0xbfc00008 in order; pcD/instrD match; first instrD_valid 3 cycles after resetn rises.
- id_ready = 0 for 5 cycles with a valid buffer -> inst_req stays 0 and instrD/pcD stay constant; after id_ready = 1, the next fetch address is pcD+4.
- redirect_valid with redirect_pc = 0x80001000 while in WAIT, data_ok 2 cycles later -> that data is never presented; next inst_addr = 0x80001000.
- flush (flush_pc = 0xbfc00380) and redirect (0x80002000) in the same cycle while in REQ with addr_ok delayed 3 cycles -> inst_addr held for the 3 cycles; returned data discarded; next fetch 0xbfc00380.
- redirect_pc = 0x80000002 -> no inst_req; buffer shows pcD = 0x80000002, instrD = 0, excodeD = 0x04; stays in HALT until flush_pc = 0xbfc00380, then resumes fetch there.
- pc_next = 0xfffffffc -> fetch at 0xfffffffc, then 0x00000000; resetn low during WAIT -> all outputs return to reset values the next cycle and a stray data_ok is ignored.
